uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one uart_tx serializer between N_REQ byte producers on the tt_um_Xelef2000 top level. Each requester offers a byte on a valid/ready handshake. The arbiter latches one byte, pulses the serializer's enable, and holds off new grants until the serializer drops busy. It replaces the hard-wired constant enable and data on the UART transmit path.

---
 rtl/uart_arb_pkg.sv | 25 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// The TAG_* states exist only when UART_ARB_TAG_EN is defined.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
`ifdef UART_ARB_TAG_EN
    ,
    TAG_ISSUE,
    TAG_WAIT_ACK,
    TAG_WAIT_DONE
`endif
  } arb_state_t;

  // Marker bit placed in the MSB of a tag byte so it never aliases a data byte index.
  localparam logic TAG_MSB = 1'b1;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit at or after ptr, wrapping.
module rr_pick #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  sel
);

  logic [ID_W-1:0] idx;

  always_comb begin
    any = 1'b0;
    sel = '0;
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = ID_W'((32'(ptr) + i) % N_REQ);
      if (!any && valid[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between N_REQ byte producers.
// Define UART_ARB_TAG_EN to prefix a requester tag byte whenever the owner changes.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int unsigned N_REQ        = 4,
  parameter  int unsigned PAYLOAD_BITS = 8,
  localparam int unsigned ID_W         = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*PAYLOAD_BITS-1:0] req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          tx_en,
  output logic [PAYLOAD_BITS-1:0]       tx_data,
  input  logic                          tx_busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          active
);

  arb_state_t              state, state_next;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         sel;
  logic                    any_valid;
  logic                    grant;
  logic                    tx_en_next;
  logic [PAYLOAD_BITS-1:0] sel_data;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .any   (any_valid),
    .sel   (sel)
  );

  assign grant    = (state == IDLE) && !tx_busy && any_valid;
  assign sel_data = req_data[sel*PAYLOAD_BITS +: PAYLOAD_BITS];

`ifdef UART_ARB_TAG_EN
  logic                    last_valid;
  logic [ID_W-1:0]         last_id;
  logic [PAYLOAD_BITS-1:0] hold_data;
  logic                    need_tag;
  logic [PAYLOAD_BITS-1:0] tag_byte;

  assign need_tag = !last_valid || (last_id != sel);
  assign tag_byte = {TAG_MSB, {(PAYLOAD_BITS-1-ID_W){1'b0}}, sel};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
`ifdef UART_ARB_TAG_EN
      IDLE:          if (grant) state_next = need_tag ? TAG_ISSUE : ISSUE;
      TAG_ISSUE:     state_next = TAG_WAIT_ACK;
      TAG_WAIT_ACK:  if (tx_busy) state_next = TAG_WAIT_DONE;
      TAG_WAIT_DONE: if (!tx_busy) state_next = ISSUE;
`else
      IDLE:          if (grant) state_next = ISSUE;
`endif
      ISSUE:         state_next = WAIT_ACK;
      WAIT_ACK:      if (tx_busy) state_next = WAIT_DONE;
      WAIT_DONE:     if (!tx_busy) state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready = N_REQ'(1) << sel;
`ifdef UART_ARB_TAG_EN
    tx_en_next = (state_next == ISSUE) || (state_next == TAG_ISSUE);
`else
    tx_en_next = (state_next == ISSUE);
`endif
  end

  // tx_en/active are registered from state_next so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      tx_en    <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      active   <= 1'b0;
`ifdef UART_ARB_TAG_EN
      last_valid <= 1'b0;
      last_id    <= '0;
      hold_data  <= '0;
`endif
    end else begin
      tx_en  <= tx_en_next;
      active <= (state_next != IDLE);
      if (grant) begin
        grant_id <= sel;
        rr_ptr   <= ID_W'(rr_next(32'(sel), N_REQ));
`ifdef UART_ARB_TAG_EN
        last_valid <= 1'b1;
        last_id    <= sel;
        hold_data  <= sel_data;
        tx_data    <= need_tag ? tag_byte : sel_data;
`else
        tx_data  <= sel_data;
`endif
      end
`ifdef UART_ARB_TAG_EN
      if ((state == TAG_WAIT_DONE) && !tx_busy) tx_data <= hold_data;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple serializer busy model.
module tb_uart_tx_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned PB    = 8;
  localparam int unsigned FRAME = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*PB-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          tx_en;
  logic [PB-1:0] tx_data;
  logic          tx_busy;
  logic [1:0]    grant_id;
  logic          active;

  logic          force_busy = 1'b0;
  int unsigned   busy_cnt = 0;
  logic [7:0]    sent[$];
  int unsigned   rdy_cnt[N];
  int unsigned   base[N];
  int            vectors = 0;
  int            miscompares = 0;
  int unsigned   sbase;
  int unsigned   bad;

  uart_tx_arbiter #(.N_REQ(N), .PAYLOAD_BITS(PB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  always #5 clk = ~clk;

  assign tx_busy = (busy_cnt != 0) || force_busy;

  initial for (int i = 0; i < N; i++) rdy_cnt[i] = 0;

  always @(posedge clk) begin
    if (tx_en === 1'b1) begin
      busy_cnt <= FRAME;
      sent.push_back(tx_data);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) rdy_cnt[i] <= rdy_cnt[i] + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tx_en(input string tag);
    int unsigned n = 0;
    do begin
      tick();
      n++;
    end while (tx_en !== 1'b1 && n < 300);
    check({tag, " tx_en seen"}, 32'(tx_en), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while ((active !== 1'b0 || tx_busy !== 1'b0) && n < 500) begin
      tick();
      n++;
    end
    check({tag, " idle"}, 32'(active), 32'd0);
  endtask

  function automatic logic [31:0] sent_at(input int unsigned i);
    return (i < sent.size()) ? 32'(sent[i]) : 32'hDEAD;
  endfunction

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0;
    tick(); tick();
    check("rst tx_en",     32'(tx_en),     32'd0);
    check("rst tx_data",   32'(tx_data),   32'd0);
    check("rst grant_id",  32'(grant_id),  32'd0);
    check("rst active",    32'(active),    32'd0);
    check("rst req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // single requester, byte 0x55 on id1
    sbase = sent.size();
    req_data = {8'h00, 8'h00, 8'h55, 8'h00};
    req_valid = 4'b0010;
    #1 check("s1 req_ready", 32'(req_ready), 32'h2);
    tick();
    check("s1 tx_en",      32'(tx_en),     32'd1);
    check("s1 tx_data",    32'(tx_data),   32'h55);
    check("s1 grant_id",   32'(grant_id),  32'd1);
    check("s1 active",     32'(active),    32'd1);
    check("s1 ready in ISSUE", 32'(req_ready), 32'd0);
    req_valid = '0;
    tick();
    check("s1 tx_en pulse", 32'(tx_en), 32'd0);
    wait_idle("s1");
    check("s1 wire byte", sent_at(sbase), 32'h55);

    // all four valid from rr_ptr=0
    rst = 1'b1; tick(); rst = 1'b0;
    sbase = sent.size();
    for (int i = 0; i < N; i++) base[i] = rdy_cnt[i];
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_valid = 4'b1111;
    begin
      int unsigned n = 0;
      while (sent.size() < sbase + 5 && n < 1000) begin
        tick();
        n++;
      end
    end
    req_valid = '0;
    check("s2 frame0", sent_at(sbase),     32'hA0);
    check("s2 frame1", sent_at(sbase + 1), 32'hA1);
    check("s2 frame2", sent_at(sbase + 2), 32'hA2);
    check("s2 frame3", sent_at(sbase + 3), 32'hA3);
    check("s2 frame4", sent_at(sbase + 4), 32'hA0);
    check("s2 ready id0", rdy_cnt[0] - base[0], 32'd2);
    check("s2 ready id1", rdy_cnt[1] - base[1], 32'd1);
    check("s2 ready id3", rdy_cnt[3] - base[3], 32'd1);
    wait_idle("s2");

    // serve id3, then id0 and id2 contend: pointer wraps to id0
    req_valid = 4'b1000;
    wait_tx_en("s3a");
    check("s3 grant id3", 32'(grant_id), 32'd3);
    req_valid = '0;
    wait_idle("s3a");
    req_valid = 4'b0101;
    #1 check("s3 wrap ready", 32'(req_ready), 32'h1);
    tick();
    check("s3 grant id0", 32'(grant_id), 32'd0);
    check("s3 data id0",  32'(tx_data),  32'hA0);
    wait_tx_en("s3b");
    check("s3 grant id2", 32'(grant_id), 32'd2);
    check("s3 data id2",  32'(tx_data),  32'hA2);
    req_valid = '0;
    wait_idle("s3b");

    // busy held high in IDLE blocks grants
    force_busy = 1'b1;
    req_valid = 4'b0001;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      #1 if (req_ready !== '0) bad++;
      tick();
      if (tx_en !== 1'b0 || active !== 1'b0) bad++;
    end
    check("s4 no grant while busy", bad, 32'd0);
    force_busy = 1'b0;
    #1 check("s4 ready after busy", 32'(req_ready), 32'h1);
    tick();
    check("s4 tx_en", 32'(tx_en), 32'd1);
    check("s4 grant id0", 32'(grant_id), 32'd0);
    req_valid = '0;
    wait_idle("s4");

    // reset during WAIT_DONE, pending requester regranted afterwards
    req_valid = 4'b0010;
    wait_tx_en("s5a");
    check("s5 grant id1", 32'(grant_id), 32'd1);
    tick(); tick(); tick();
    check("s5 in WAIT_DONE", 32'(active), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s5 rst tx_en",    32'(tx_en),    32'd0);
    check("s5 rst tx_data",  32'(tx_data),  32'd0);
    check("s5 rst grant_id", 32'(grant_id), 32'd0);
    check("s5 rst active",   32'(active),   32'd0);
    #1 check("s5 ready while busy", 32'(req_ready), 32'd0);
    wait_tx_en("s5b");
    check("s5 regrant id1", 32'(grant_id), 32'd1);
    check("s5 regrant data", 32'(tx_data), 32'hA1);
    req_valid = '0;
    wait_idle("s5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
